// File: rtl/leb128_reader.sv
//==============================================================================
// leb128_reader - ROM byte fetch and 32-bit u/sLEB128 decoder with a one-byte cache. Rev 1.0
//==============================================================================
`default_nettype none

module leb128_reader #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        signed_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] value,
  output logic [2:0]  byte_count,
  output logic [31:0] next_addr,
  output logic        error,
  output logic [31:0] rom_addr,
  output logic        rom_read_en,
  input  logic [7:0]  rom_data,
  input  logic        rom_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   cur_addr;
  logic [31:0]   acc;
  logic [2:0]    count;
  logic [TW-1:0] tcnt;
  logic          sgn;
  logic          cache_valid;
  logic [31:0]   cache_addr;
  logic [7:0]    cache_data;

  logic          hit;
  logic          take;
  logic [7:0]    byte_in;
  logic [2:0]    count_next;
  logic [5:0]    shamt;
  logic [5:0]    shamt_next;
  logic [31:0]   acc_next;
  logic [31:0]   ext_mask;
  logic [31:0]   addr_next;

  assign hit        = (state == FETCH) && cache_valid && (cache_addr == cur_addr);
  assign take       = hit || ((state == FETCH) && rom_ready);
  assign byte_in    = hit ? cache_data : rom_data;
  assign count_next = count + 3'd1;
  // 7*n computed as 8*n - n to stay in a 6-bit shift amount
  assign shamt      = ({3'b000, count} << 3) - {3'b000, count};
  assign shamt_next = ({3'b000, count_next} << 3) - {3'b000, count_next};
  assign acc_next   = acc | ({25'd0, byte_in[6:0]} << shamt);
  assign ext_mask   = (sgn && byte_in[6] && (shamt_next < 6'd32)) ?
                      (32'hFFFF_FFFF << shamt_next) : 32'd0;
  assign addr_next  = cur_addr + 32'd1;

  assign rom_read_en = (state == FETCH) && !hit;
  assign rom_addr    = cur_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= 32'd0;
      acc         <= 32'd0;
      count       <= 3'd0;
      tcnt        <= '0;
      sgn         <= 1'b0;
      cache_valid <= 1'b0;
      cache_addr  <= 32'd0;
      cache_data  <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      value       <= 32'd0;
      byte_count  <= 3'd0;
      next_addr   <= 32'd0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr <= start_addr;
            sgn      <= signed_mode;
            acc      <= 32'd0;
            count    <= 3'd0;
            tcnt     <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (take) begin
            acc      <= acc_next;
            count    <= count_next;
            cur_addr <= addr_next;
            tcnt     <= '0;
            if (!hit) begin
              cache_valid <= 1'b1;
              cache_addr  <= cur_addr;
              cache_data  <= rom_data;
            end
            if (!byte_in[7]) begin
              value      <= acc_next | ext_mask;
              byte_count <= count_next;
              next_addr  <= addr_next;
              error      <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else if (count_next == 3'd5) begin
              value      <= acc_next;
              byte_count <= count_next;
              next_addr  <= addr_next;
              error      <= 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end
          end else if (tcnt == TW'(TIMEOUT)) begin
            value      <= acc;
            byte_count <= count;
            next_addr  <= cur_addr;
            error      <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_leb128_reader.sv
//==============================================================================
// tb_leb128_reader - scoreboard bench: stimulus pushes model results, monitor pops on done. Rev 1.0
//==============================================================================
`default_nettype none

module tb_leb128_reader;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [31:0] value;
  logic [2:0]  byte_count;
  logic [31:0] next_addr;
  logic        error;
  logic [31:0] rom_addr;
  logic        rom_read_en;
  logic [7:0]  rom_data;
  logic        rom_ready;

  leb128_reader #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_addr  (start_addr),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .value       (value),
    .byte_count  (byte_count),
    .next_addr   (next_addr),
    .error       (error),
    .rom_addr    (rom_addr),
    .rom_read_en (rom_read_en),
    .rom_data    (rom_data),
    .rom_ready   (rom_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [2:0]  cnt;
    logic [31:0] naddr;
    logic        err;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  mem [1024];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rises = 0;
  logic        en_d = 1'b0;
  logic        rom_mute = 1'b0;
  logic        prev_en;
  logic [31:0] prev_addr;
  // model of the last byte the reader fetched from ROM
  logic        mc_valid = 1'b0;
  logic [31:0] mc_addr = 32'd0;
  logic [7:0]  mc_data = 8'd0;

  // ROM: answers one cycle after a read request appears or its address changes
  always @(posedge clk) begin
    if (rst) begin
      rom_ready <= 1'b0;
      rom_data  <= 8'd0;
      prev_en   <= 1'b0;
      prev_addr <= 32'd0;
    end else begin
      rom_ready <= rom_read_en && !rom_mute && (!prev_en || rom_addr != prev_addr);
      rom_data  <= mem[rom_addr[9:0]];
      prev_en   <= rom_read_en;
      prev_addr <= rom_addr;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    en_d <= rom_read_en;
    if (rom_read_en && !en_d) rises <= rises + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        check("value", value, mon_e.value);
        check("byte_count", {29'd0, byte_count}, {29'd0, mon_e.cnt});
        check("next_addr", next_addr, mon_e.naddr);
        check("error", {31'd0, error}, {31'd0, mon_e.err});
        check("latency", cyc - mon_e.start_cyc, mon_e.lat);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Reference decode: arithmetic LEB128 with an explicit last-byte cache and cycle costs
  function automatic exp_t model(input logic [31:0] a, input logic sm);
    exp_t        e;
    longint      v = 0;
    int          n = 0;
    int          lat = 0;
    logic [31:0] ad = a;
    logic [7:0]  b;
    e.err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mc_valid && mc_addr == ad) begin
        b = mc_data;
        lat += 1;
      end else if (rom_mute) begin
        lat += TIMEOUT + 1;
        e.err = 1'b1;
        break;
      end else begin
        b = mem[ad[9:0]];
        lat += 2;
        mc_valid = 1'b1;
        mc_addr  = ad;
        mc_data  = b;
      end
      v += longint'({57'd0, b[6:0]}) << (7 * n);
      n++;
      ad = ad + 32'd1;
      if (!b[7]) begin
        if (sm && b[6] && 7 * n < 32) v = v - (longint'(1) << (7 * n));
        break;
      end
      if (n == 5) e.err = 1'b1;
    end
    e.value = v[31:0];
    e.cnt   = 3'(n);
    e.naddr = ad;
    e.lat   = lat;
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got no done within 60 cycles expected done");
      q.delete();
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic sm);
    exp_t e;
    @(negedge clk);
    e = model(a, sm);
    e.start_cyc = cyc + 1;
    q.push_back(e);
    start       = 1'b1;
    start_addr  = a;
    signed_mode = sm;
    @(negedge clk);
    start       = 1'b0;
    start_addr  = $urandom;
    signed_mode = 1'($urandom);
    wait_done();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_value"}, value, 32'd0);
    check({tag, "_byte_count"}, {29'd0, byte_count}, 32'd0);
    check({tag, "_next_addr"}, next_addr, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_rom_read_en"}, {31'd0, rom_read_en}, 32'd0);
    check({tag, "_rom_addr"}, rom_addr, 32'd0);
  endtask

  task automatic put(input int a, input logic [7:0] b);
    mem[a[9:0]] = b;
  endtask

  initial begin
    int          r0;
    int          len;
    int          off;
    logic [31:0] a;
    logic [7:0]  b;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    put(32'h10, 8'h05);
    put(32'h20, 8'hE5); put(32'h21, 8'h8E); put(32'h22, 8'h26);
    put(32'h30, 8'h7F);
    put(32'h40, 8'hC0); put(32'h41, 8'hBB); put(32'h42, 8'h78);
    for (int i = 0; i < 5; i++) put(32'h50 + i, 8'h80);
    put(32'h200, 8'h81); put(32'h201, 8'h82); put(32'h202, 8'h03);

    rst = 1'b1; start = 1'b0; start_addr = 32'd0; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    issue(32'h10, 1'b0);
    r0 = rises;
    issue(32'h20, 1'b0);
    check("multi_read_en_rises", rises - r0, 1);
    issue(32'h30, 1'b1);
    issue(32'h40, 1'b1);
    issue(32'h50, 1'b0);
    issue(32'h10, 1'b0);
    r0 = rises;
    issue(32'h10, 1'b0);
    check("hit_read_en_rises", rises - r0, 0);

    rom_mute = 1'b1;
    issue(32'h300, 1'b0);
    rom_mute = 1'b0;

    // reset while the second byte of 0x200 is outstanding
    @(negedge clk);
    start = 1'b1; start_addr = 32'h200; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    mc_valid = 1'b0;
    r0 = rises;
    issue(32'h200, 1'b0);
    check("post_reset_read_en_rises", rises - r0, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0 && mc_valid) begin
        issue(mc_addr, 1'($urandom));
      end else begin
        off = $urandom_range(0, 1018);
        a   = ($urandom & 32'hFFFF_FC00) | 32'(off);
        len = $urandom_range(1, 6);
        for (int i = 0; i < 5 && i < len; i++) begin
          b = 8'($urandom);
          b[7] = (i < len - 1 || len == 6);
          put(off + i, b);
        end
        issue(a, 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
